// File: rtl/foc_loop_sequencer.sv
// Per-PWM-period FOC current-loop scheduler: ADC -> Clarke/Park -> d/q PI -> inverse Park/SVPWM.
// Define SPEED_LOOP_EN to add the speed-loop stage (SPD) between PARK and PI every SPEED_DIV loops.
module foc_loop_sequencer #(
  parameter int LOOP_DIV       = 1,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int SPEED_DIV      = 10
) (
  input  logic       iClk,
  input  logic       iRst_n,
  input  logic       iPwm_sync,
  input  logic       iAdc_done,
  input  logic       iPark_done,
  input  logic       iPid_done,
  input  logic       iPiq_done,
  input  logic       iSvpwm_done,
  input  logic       iFault_clr,
`ifdef SPEED_LOOP_EN
  input  logic       iSpd_done,
  output logic       oSpd_start,
`endif
  output logic       oAdc_start,
  output logic       oPark_start,
  output logic       oPi_en,
  output logic       oSvpwm_start,
  output logic       oBusy,
  output logic       oLoop_done,
  output logic       oPwm_en,
  output logic       oFault,
  output logic       oOverrun,
  output logic [2:0] oFault_stage
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADC, S_PARK, S_PI, S_SVPWM, S_DONE,
`ifdef SPEED_LOOP_EN
    S_SPD,
`endif
    S_FAULT
  } state_t;

  localparam logic [7:0]  DIV_LAST = 8'(LOOP_DIV - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [15:0] timer;
  logic        pid_lat, piq_lat;
  logic        pid_hit, piq_hit;
  logic        stage_done;
  logic [2:0]  stage_code;
  logic        busy_state;
  logic        tmo;
`ifdef SPEED_LOOP_EN
  localparam logic [15:0] SPD_LAST = 16'(SPEED_DIV - 1);
  logic [15:0] loop_cnt;
  logic        spd_due;
  assign spd_due = (loop_cnt == SPD_LAST);
`endif

  // Dones seen while the entry strobe is still high belong to a previous stage and are ignored.
  assign pid_hit    = pid_lat | (iPid_done & ~oPi_en);
  assign piq_hit    = piq_lat | (iPiq_done & ~oPi_en);
  assign busy_state = (state != S_IDLE) && (state != S_FAULT);
  assign tmo        = (timer == TMO_LAST);

  // Per-stage completion condition and fault code; code 0 marks a non-stage state.
  always_comb begin
    stage_code = 3'd0;
    stage_done = 1'b0;
    case (state)
      S_ADC:   begin stage_code = 3'd1; stage_done = iAdc_done & ~oAdc_start;     end
      S_PARK:  begin stage_code = 3'd2; stage_done = iPark_done & ~oPark_start;   end
      S_PI:    begin stage_code = 3'd3; stage_done = pid_hit & piq_hit;           end
      S_SVPWM: begin stage_code = 3'd4; stage_done = iSvpwm_done & ~oSvpwm_start; end
`ifdef SPEED_LOOP_EN
      S_SPD:   begin stage_code = 3'd5; stage_done = iSpd_done & ~oSpd_start;     end
`endif
      default: begin stage_code = 3'd0; stage_done = 1'b0; end
    endcase
  end

  // Sequencer state, divider, stage timer, PI-done latches and all registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state        <= S_IDLE;
      div_cnt      <= 8'd0;
      timer        <= 16'd0;
      pid_lat      <= 1'b0;
      piq_lat      <= 1'b0;
      oAdc_start   <= 1'b0;
      oPark_start  <= 1'b0;
      oPi_en       <= 1'b0;
      oSvpwm_start <= 1'b0;
      oBusy        <= 1'b0;
      oLoop_done   <= 1'b0;
      oPwm_en      <= 1'b0;
      oFault       <= 1'b0;
      oOverrun     <= 1'b0;
      oFault_stage <= 3'd0;
`ifdef SPEED_LOOP_EN
      loop_cnt     <= 16'd0;
      oSpd_start   <= 1'b0;
`endif
    end else begin
      oAdc_start   <= 1'b0;
      oPark_start  <= 1'b0;
      oPi_en       <= 1'b0;
      oSvpwm_start <= 1'b0;
      oLoop_done   <= 1'b0;
`ifdef SPEED_LOOP_EN
      oSpd_start   <= 1'b0;
`endif
      timer   <= timer + 16'd1;
      pid_lat <= (state == S_PI) ? pid_hit : 1'b0;
      piq_lat <= (state == S_PI) ? piq_hit : 1'b0;
      // A new sync arriving mid-loop is never lost to a simultaneous clear.
      if (iPwm_sync && busy_state) begin
        oOverrun <= 1'b1;
      end else if (iFault_clr) begin
        oOverrun <= 1'b0;
      end
      if (stage_code != 3'd0) begin
        if (stage_done) begin
          timer <= 16'd0;
          case (state)
            S_ADC: begin state <= S_PARK; oPark_start <= 1'b1; end
            S_PARK: begin
`ifdef SPEED_LOOP_EN
              if (spd_due) begin
                state <= S_SPD; oSpd_start <= 1'b1;
              end else begin
                state <= S_PI; oPi_en <= 1'b1;
              end
`else
              state <= S_PI; oPi_en <= 1'b1;
`endif
            end
`ifdef SPEED_LOOP_EN
            S_SPD: begin state <= S_PI; oPi_en <= 1'b1; end
`endif
            S_PI: begin state <= S_SVPWM; oSvpwm_start <= 1'b1; end
            S_SVPWM: begin state <= S_DONE; oLoop_done <= 1'b1; oPwm_en <= 1'b1; end
            default: begin state <= S_IDLE; oBusy <= 1'b0; end
          endcase
        end else if (tmo) begin
          state        <= S_FAULT;
          oFault       <= 1'b1;
          oPwm_en      <= 1'b0;
          oBusy        <= 1'b0;
          oFault_stage <= stage_code;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (iPwm_sync) begin
              if (div_cnt == DIV_LAST) begin
                div_cnt    <= 8'd0;
                state      <= S_ADC;
                timer      <= 16'd0;
                oAdc_start <= 1'b1;
                oBusy      <= 1'b1;
              end else begin
                div_cnt <= div_cnt + 8'd1;
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            oBusy <= 1'b0;
`ifdef SPEED_LOOP_EN
            loop_cnt <= spd_due ? 16'd0 : loop_cnt + 16'd1;
`endif
          end
          S_FAULT: begin
            if (iFault_clr) begin
              state        <= S_IDLE;
              oFault       <= 1'b0;
              oFault_stage <= 3'd0;
            end
          end
          default: begin state <= S_IDLE; oBusy <= 1'b0; end
        endcase
      end
    end
  end

endmodule
